// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer
module multicycle_sequencer #(
  parameter int               XLEN        = 32,
  parameter int               MEM_TIMEOUT = 16,
  parameter logic [XLEN-1:0]  NOP_INSTR   = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  input  logic            regwrite_control,
  input  logic            mem_read_control,
  input  logic            mem_write_control,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            rf_we,
  output logic            pc_en,
  output logic [31:0]     instret,
  output logic            bus_error,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ERROR   = 3'd7
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          mem_op;
  logic          ex_retire;
  logic          mem_retire;

  assign mem_op      = mem_read_control | mem_write_control;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= NOP_INSTR;
      instret   <= '0;
      bus_error <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          wait_cnt <= '0;
          if (mem_op) begin
            state <= S_MEM;
          end else if (regwrite_control) begin
            state <= S_WB;
          end else begin
            instret <= instret + 32'd1;
            state   <= S_FETCH;
          end
        end
        S_MEM: begin
          // ready on the limit cycle still completes; only a miss there traps
          if (dmem_ready) begin
            wait_cnt <= '0;
            if (mem_write_control) begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end else if (timeout_hit) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          instret  <= instret + 32'd1;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_ERROR: bus_error <= 1'b1;
        default: begin
          state     <= S_ERROR;
          bus_error <= 1'b1;
        end
      endcase
    end
  end

  // Retire strobes depend on this cycle's ready/flags so retirement costs no extra cycle
  assign ex_retire  = (state == S_EXECUTE) && !mem_op && !regwrite_control;
  assign mem_retire = (state == S_MEM) && dmem_ready && mem_write_control;

  assign imem_req = !rst && (state == S_FETCH);
  assign dmem_req = !rst && (state == S_MEM);
  assign dmem_we  = !rst && (state == S_MEM) && mem_write_control;
  assign rf_we    = !rst && (state == S_WB);
  assign pc_en    = !rst && (ex_retire || mem_retire || (state == S_WB));
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata, ir;
  logic        regwrite_control, mem_read_control, mem_write_control;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        rf_we, pc_en, bus_error;
  logic [31:0] instret;
  logic [2:0]  state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.XLEN(32), .MEM_TIMEOUT(4), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir),
    .regwrite_control(regwrite_control), .mem_read_control(mem_read_control),
    .mem_write_control(mem_write_control),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_en(pc_en), .instret(instret),
    .bus_error(bus_error), .state_o(state_o)
  );

  // Runs one instruction. cls: 0 nop, 1 alu, 2 load, 3 store, 4 read+write (store).
  // fw/dw are the number of not-ready cycles before the fetch/data handshake.
  task automatic run_instr(input string name, input int cls, input int fw, input int dw,
                           input logic [31:0] instr);
    logic r, mr, mw, is_mem, is_store, is_wb;
    int   exp_cycles, cyc, fs, ds, rfc, mis, we_bad;
    bit   done;
    r  = (cls == 1 || cls == 2 || (cls == 4 && $urandom_range(0, 1) == 1));
    mr = (cls == 2 || cls == 4);
    mw = (cls == 3 || cls == 4);
    is_mem   = mr | mw;
    is_store = mw;
    is_wb    = is_mem ? !mw : r;
    exp_cycles = (fw + 1) + 2 + (is_mem ? dw + 1 : 0) + (is_wb ? 1 : 0);
    regwrite_control  = r;
    mem_read_control  = mr;
    mem_write_control = mw;
    cyc = 0; fs = 0; ds = 0; rfc = 0; mis = 0; we_bad = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      imem_ready = imem_req && (fs == fw);
      imem_rdata = imem_ready ? instr : $urandom;
      dmem_ready = dmem_req && (ds == dw);
      #1;
      if (imem_req) fs++;
      if (dmem_req) begin
        ds++;
        if (dmem_we !== is_store) we_bad++;
      end
      if (rf_we) rfc++;
      if (rf_we && !pc_en) mis++;
      if (pc_en) done = 1;
      cyc++;
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (done) exp_instret = exp_instret + 32'd1;
    n_checks++; if (!done) begin n_fail++; $display("FAIL %s retire: no pc_en within 40 cycles", name); end
    n_checks++; if (cyc !== exp_cycles) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cycles); end
    n_checks++; if (fs !== fw + 1) begin n_fail++; $display("FAIL %s imem_req cycles: got %0d expected %0d", name, fs, fw + 1); end
    n_checks++; if (ds !== (is_mem ? dw + 1 : 0)) begin n_fail++; $display("FAIL %s dmem_req cycles: got %0d expected %0d", name, ds, is_mem ? dw + 1 : 0); end
    n_checks++; if (we_bad !== 0) begin n_fail++; $display("FAIL %s dmem_we: %0d cycles got wrong value, expected %0b", name, we_bad, is_store); end
    n_checks++; if (rfc !== (is_wb ? 1 : 0) || mis !== 0) begin n_fail++; $display("FAIL %s rf_we: got %0d pulses (%0d without pc_en) expected %0d", name, rfc, mis, is_wb ? 1 : 0); end
    n_checks++; if (instret !== exp_instret) begin n_fail++; $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret); end
    n_checks++; if (ir !== instr) begin n_fail++; $display("FAIL %s ir: got %h expected %h", name, ir, instr); end
    n_checks++; if (state_o !== 3'd0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL %s post-state: got state %0d err %0b expected 0 0", name, state_o, bus_error); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if ({imem_req, dmem_req, dmem_we, rf_we, pc_en} !== 5'b0) begin n_fail++; $display("FAIL reset strobes: got %b expected 00000", {imem_req, dmem_req, dmem_we, rf_we, pc_en}); end
    @(posedge clk);
    #1;
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset state: got %0d expected 0", state_o); end
    n_checks++; if (ir !== 32'h00000013) begin n_fail++; $display("FAIL reset ir: got %h expected 00000013", ir); end
    n_checks++; if (instret !== 32'd0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL reset counters: got instret %0d err %0b expected 0 0", instret, bus_error); end
    rst = 1'b0;
    exp_instret = 0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset release imem_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr("random", $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    seen = 0;
    regwrite_control = 1'b1; mem_read_control = 1'b1; mem_write_control = 1'b0;
    dmem_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      #1;
      if (dmem_req) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midmem reach: dmem_req never asserted within 10 cycles"); end
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL midmem req drop: got dmem %b imem %b expected 0 0", dmem_req, imem_req); end
    @(posedge clk);
    #1;
    n_checks++; if (state_o !== 3'd0 || ir !== 32'h00000013 || instret !== 32'd0) begin n_fail++; $display("FAIL midmem reset: got state %0d ir %h instret %0d expected 0 00000013 0", state_o, ir, instret); end
    rst = 1'b0;
    exp_instret = 0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midmem restart imem_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    do_reset();
    imem_ready = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (imem_req) req_cycles++;
    end
    n_checks++; if (req_cycles !== 4) begin n_fail++; $display("FAIL timeout fetch cycles: got %0d expected 4", req_cycles); end
    @(posedge clk);
    #1;
    n_checks++; if (state_o !== 3'd7 || bus_error !== 1'b1) begin n_fail++; $display("FAIL timeout trap: got state %0d err %0b expected 7 1", state_o, bus_error); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
      n_checks++; if ({imem_req, dmem_req, rf_we, pc_en} !== 4'b0 || state_o !== 3'd7) begin n_fail++; $display("FAIL timeout hold: got strobes %b state %0d expected 0000 7", {imem_req, dmem_req, rf_we, pc_en}, state_o); end
    end
    imem_ready = 1'b0;
    do_reset();
    n_checks++; if (bus_error !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL timeout clear: got err %b state %0d expected 0 0", bus_error, state_o); end
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
    regwrite_control = 1'b0; mem_read_control = 1'b0; mem_write_control = 1'b0;
    test_reset();
    run_instr("alu", 1, 0, 0, 32'h002081B3);
    run_instr("load", 2, 0, 2, 32'h0000A103);
    run_instr("store", 3, 0, 0, 32'h0020A023);
    run_instr("nop", 0, 0, 0, 32'h00000013);
    run_instr("both_rw", 4, 1, 1, 32'h12345678);
    run_instr("ready_at_limit_mem", 2, 0, 3, 32'hCAFEF00D);
    run_instr("ready_at_limit_fetch", 1, 3, 0, 32'h00A50533);
    test_random(40);
    test_reset_mid_mem();
    run_instr("after_midmem", 1, 0, 0, 32'h00B585B3);
    test_timeout();
    run_instr("after_timeout", 3, 2, 1, 32'h00C62023);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
